// File: rtl/kalman_pkg.sv
// kalman_pkg
// Shared definitions for the Kalman sequencer and its address generator.
//   - addr_sel bit positions (increment / restart strobes per region)
//   - sequencer FSM state type
//   - offset_width(): width of the addr_ptr bus (region bit + offset field)
package kalman_pkg;

    localparam int SEL_INC_STATES = 0;
    localparam int SEL_RST_STATES = 1;
    localparam int SEL_INC_COMMON = 2;
    localparam int SEL_RST_COMMON = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // The offset field is sized to hold the larger per-state increment value
    // itself (the generator adds it to its base), plus one MSB for the region.
    function automatic int offset_width(input int steps_states, input int steps_common);
        int m;
        m = (steps_states > steps_common) ? steps_states : steps_common;
        return $clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/kalman_step_counter.sv
// kalman_step_counter
// Step counter (0 .. STEPS_TOTAL-1) and state counter (0 .. N_STATES-1).
// Both advance on i_adv; the state counter steps when the step counter wraps
// and returns to 0 after the final step of the final state.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_adv            advance one step
//   o_step           current step within the state
//   o_state          current state index
//   o_last_step      o_step is the last step of a state
//   o_last_state     o_state is the last state of the run
module kalman_step_counter
    import kalman_pkg::*;
#(
    parameter int N_STATES    = 8,
    parameter int STEPS_TOTAL = 4,
    parameter int STEP_W      = 2,
    parameter int IDX_W       = 3
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adv,
    output logic [STEP_W-1:0] o_step,
    output logic [IDX_W-1:0]  o_state,
    output logic              o_last_step,
    output logic              o_last_state
);

    logic [STEP_W-1:0] r_step;
    logic [IDX_W-1:0]  r_state;

    assign o_step       = r_step;
    assign o_state      = r_state;
    assign o_last_step  = (r_step == STEP_W'(STEPS_TOTAL - 1));
    assign o_last_state = (r_state == IDX_W'(N_STATES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step  <= '0;
            r_state <= '0;
        end else if (i_adv) begin
            if (o_last_step) begin
                r_step  <= '0;
                r_state <= o_last_state ? '0 : r_state + IDX_W'(1);
            end else begin
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/kalman_sequencer.sv
// kalman_sequencer
// Control stage in front of the Kalman address generator. A start pulse
// launches a run over N_STATES states; each state issues STEPS_STATES reads
// from the state region then STEPS_COMMON reads from the common region.
// Optional feature macro: KALMAN_SEQ_STALL_EN (adds i_stall to pause a run).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          run request (accepted only while o_busy=0)
//   i_stall          (KALMAN_SEQ_STALL_EN only) hold the sequence
//   o_busy           run in progress, high through the o_done cycle
//   o_done           pulse with the last o_rd_valid
//   o_addr_sel       generator strobes {rst common, inc common, rst states, inc states}
//   o_addr_ptr       {region, offset} to the generator
//   o_rd_valid       generator output address valid this cycle
//   o_state_idx      state index aligned with o_rd_valid
module kalman_sequencer
    import kalman_pkg::*;
#(
    parameter  int N_STATES     = 8,
    parameter  int STEPS_STATES = 2,
    parameter  int STEPS_COMMON = 2,
    localparam int OFFSET_WIDTH = offset_width(STEPS_STATES, STEPS_COMMON),
    localparam int IDX_W        = (N_STATES > 1) ? $clog2(N_STATES) : 1
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
`ifdef KALMAN_SEQ_STALL_EN
    input  logic                    i_stall,
`endif
    output logic                    o_busy,
    output logic                    o_done,
    output logic [3:0]              o_addr_sel,
    output logic [OFFSET_WIDTH-1:0] o_addr_ptr,
    output logic                    o_rd_valid,
    output logic [IDX_W-1:0]        o_state_idx
);

    localparam int STEPS_TOTAL = STEPS_STATES + STEPS_COMMON;
    localparam int STEP_W      = $clog2(STEPS_TOTAL);
    localparam int OFF_W       = OFFSET_WIDTH - 1;

    seq_state_t              r_fsm, w_fsm_next;
    logic                    w_stall, w_accept, w_issue, w_final;
    logic [STEP_W-1:0]       w_step, w_rel;
    logic [IDX_W-1:0]        w_state_cnt;
    logic                    w_last_step, w_last_state, w_in_states;
    logic [OFF_W-1:0]        w_off;
    logic [3:0]              w_sel;

    logic                    r_busy, r_done, r_rd_valid;
    logic [3:0]              r_addr_sel;
    logic [OFFSET_WIDTH-1:0] r_addr_ptr;
    logic [IDX_W-1:0]        r_step_state, r_state_idx;
    logic                    r_step_act, r_final_p;

`ifdef KALMAN_SEQ_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    kalman_step_counter #(
        .N_STATES   (N_STATES),
        .STEPS_TOTAL(STEPS_TOTAL),
        .STEP_W     (STEP_W),
        .IDX_W      (IDX_W)
    ) u_step_counter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_adv       (w_issue),
        .o_step      (w_step),
        .o_state     (w_state_cnt),
        .o_last_step (w_last_step),
        .o_last_state(w_last_state)
    );

    assign w_final     = w_last_step && w_last_state;
    assign w_in_states = (w_step < STEP_W'(STEPS_STATES));
    assign w_rel       = w_in_states ? w_step : w_step - STEP_W'(STEPS_STATES);
    assign w_off       = OFF_W'(w_rel);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_fsm <= ST_IDLE;
        else          r_fsm <= w_fsm_next;
    end

    // Step 0 is issued in the same edge that accepts start, so the first
    // address appears one cycle after the start pulse.
    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        w_issue    = 1'b0;
        w_sel      = '0;
        case (r_fsm)
            ST_IDLE: begin
                if (i_start && !r_busy) begin
                    w_accept   = 1'b1;
                    w_issue    = 1'b1;
                    w_fsm_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_stall) begin
                    w_issue = 1'b1;
                    if (w_final) w_fsm_next = ST_IDLE;
                end
            end
            default: w_fsm_next = ST_IDLE;
        endcase
        if (w_last_step) begin
            if (w_last_state) begin
                w_sel[SEL_RST_STATES] = 1'b1;
                w_sel[SEL_RST_COMMON] = 1'b1;
            end else begin
                w_sel[SEL_INC_STATES] = 1'b1;
                w_sel[SEL_INC_COMMON] = 1'b1;
            end
        end
    end

    // r_step_act/r_final_p track the issued step; the rd_valid, state_idx and
    // done registers delay them once more to match the generator's output reg.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_addr_sel   <= '0;
            r_addr_ptr   <= '0;
            r_step_state <= '0;
            r_state_idx  <= '0;
            r_step_act   <= 1'b0;
            r_final_p    <= 1'b0;
        end else begin
            r_addr_sel <= w_issue ? w_sel : 4'b0000;
            if (w_issue) begin
                r_addr_ptr   <= {~w_in_states, w_off};
                r_step_state <= w_state_cnt;
            end else if (r_fsm == ST_IDLE) begin
                r_addr_ptr <= '0;
            end
            r_step_act  <= w_issue;
            r_final_p   <= w_issue && w_final;
            r_rd_valid  <= r_step_act;
            r_state_idx <= r_step_state;
            r_done      <= r_step_act && r_final_p;
            if (w_accept)    r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_valid  = r_rd_valid;
    assign o_addr_sel  = r_addr_sel;
    assign o_addr_ptr  = r_addr_ptr;
    assign o_state_idx = r_state_idx;

endmodule
